matrix_unloader: RTL and testbench
==================================

Name: matrix_unloader

Overview:
- Transmit-side counterpart of the matrix load path: reads a 32x32 result matrix of 8-bit elements, one 256-bit row per read, from a simple-dual-port BRAM read port.
- Serializes the matrix as a 2-bit dibit stream (axiov/axiod) toward the Ethernet TX path, on the same dibit/element ordering the loader consumes.
- Sits between the result BRAM and the Ethernet frame transmitter, in the eth_refclk domain.

Parameters:
- MAX_ELEMENT_SIZE, 8: bits per element; must be even.
- MAX_SIZE, 32: rows per matrix and elements per row.
- READ_LATENCY, 2: BRAM read latency in cycles, from rd_en/rd_addr registered to rd_data valid (HIGH_PERFORMANCE mode).

Ports:
- eth_refclk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins transmission of the matrix.
- rd_addr  out  $clog2(MAX_SIZE)  BRAM read row address.
- rd_en  out  1  BRAM read enable.
- rd_data  in  MAX_SIZE*MAX_ELEMENT_SIZE  BRAM row data.
- axiord  in  1  downstream ready.
- axiov  out  1  dibit valid.
- axiod  out  2  dibit data.
- busy  out  1  high from start accept until done.
- done  out  1  single-cycle pulse after the last dibit is transferred.

Behaviour:
- One clock, eth_refclk. Reset is asynchronous and active-low on rst_n.
- Reset (async, takes effect immediately mid-operation): state=IDLE; axiov=0, axiod=0, rd_en=0, rd_addr=0, busy=0, done=0; all counters cleared.
- States:
  - IDLE: waits for start; start is ignored in every other state.
  - FETCH: drives rd_en=1 and rd_addr=row for one cycle, then waits READ_LATENCY cycles and latches rd_data into the row shift register.
  - SEND: streams the row.
  - DONE: one cycle with done=1, then returns to IDLE.
- Latency: start sampled at edge E0 -> rd_en=1, rd_addr=0 after E0 -> axiov=1 after edge E0+READ_LATENCY+1.
- Ordering:
  - Rows are sent 0..MAX_SIZE-1.
  - Within a row, element 0 is bits [255:248] and is sent first.
  - Within an element, the MSB dibit [7:6] is sent first.
- Handshake:
  - A transfer occurs when axiov && axiord.
  - While axiov && !axiord, axiod holds stable.
  - axiov never drops without a transfer, except on reset.
- Counters:
  - Dibit index 0..3, 2 bits, wraps.
  - Element index 0..MAX_SIZE-1.
  - Row index 0..MAX_SIZE-1.
  - Total transfers = MAX_SIZE*MAX_SIZE*MAX_ELEMENT_SIZE/2 = 4096.
- Row boundary (feature off):
  - On the last transfer of a row that is not the last row: row+1, go to FETCH, axiov=0.
  - The gap is READ_LATENCY+1 = 3 cycles of axiov=0.
- Last transfer of row MAX_SIZE-1: axiov=0 on the next edge, go to DONE. done pulses 1 cycle; busy falls in the same cycle as done.
- busy rises on the edge that accepts start.

Optional Feature:
- Macro: MATRIX_UNLOADER_PREFETCH_EN.
- Defined:
  - A second 256-bit row buffer is added.
  - The next row's read is issued on the first transfer of the current row, and the result is held in the second buffer.
  - On the last transfer of the row, the buffers swap and axiov stays high: zero gap between rows, 4096 transfers in 4096 cycles with axiord constant high.
  - No prefetch is issued during the last row.
- Undefined: the 3-cycle inter-row gap described under Behaviour.

Decomposition:
- Shared package matrix_pkg holds:
  - MAX_ELEMENT_SIZE, MAX_SIZE.
  - ROW_W = MAX_SIZE*MAX_ELEMENT_SIZE.
  - DIBITS_PER_ELEM = MAX_ELEMENT_SIZE/2.
  - State enum {IDLE, FETCH, SEND, DONE}.
  - These are reused by the loader.
- Sub-module row_serializer:
  - Loads a ROW_W row and shifts out 2 bits per accepted transfer.
  - Flags last_dibit.
  - Also holds the prefetch buffer when the feature is enabled.

Test Plan:
- Fill BRAM model with elem(r,c)=(r*32+c)&8'hFF; start; axiord=1 -> 4096 transfers; the first eight dibits are 00,00,00,00, 00,00,00,01; the last element 0xFF sends 11,11,11,11; done pulses once after the final transfer.
- Same fill; axiord low for 5 cycles at row 3, element 10, dibit 2 -> axiod holds 2'b10 (element 0x6A), axiov stays 1, no dibit lost or duplicated.
- Feature off: measure axiov=0 gap at each row boundary -> exactly 3 cycles, 31 gaps. Feature on: zero gaps; total duration from first axiov to done is 4096+1 cycles.
- Pulse start at transfer 100 while busy -> ignored; the stream is unchanged and done pulses exactly once.
- Assert rst_n=0 mid-row 7 -> axiov, rd_en, busy go 0 immediately. Release, then start -> the stream restarts at row 0, dibit 00.
- Start sampled at edge E0 -> rd_en=1 and rd_addr=0 after E0; axiov first high after E3.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared matrix geometry and the load/unload FSM state encoding, used by both
// the matrix loader and the matrix unloader.
package matrix_pkg;

  localparam int MAX_ELEMENT_SIZE = 8;
  localparam int MAX_SIZE         = 32;
  localparam int ROW_W            = MAX_SIZE * MAX_ELEMENT_SIZE;
  localparam int DIBITS_PER_ELEM  = MAX_ELEMENT_SIZE / 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/matrix_unloader_row_serializer.sv
// Row shift register for the unloader: loads one BRAM row and emits it MSB dibit
// first. With MATRIX_UNLOADER_PREFETCH_EN it also holds the next row for a gapless swap.
module row_serializer
  import matrix_pkg::*;
#(
  parameter int ROW_BITS = ROW_W,
  parameter int ELEMS    = MAX_SIZE,
  parameter int DIBITS   = DIBITS_PER_ELEM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift,
`ifdef MATRIX_UNLOADER_PREFETCH_EN
  input  logic                pf_load,
  input  logic                swap,
  output logic                first_dibit,
`endif
  input  logic [ROW_BITS-1:0] row_in,
  output logic [1:0]          dibit,
  output logic                last_dibit
);

  localparam int DIB_W = (DIBITS > 1) ? $clog2(DIBITS) : 1;
  localparam int EL_W  = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  logic [ROW_BITS-1:0] sreg_q, sreg_d;
  logic [DIB_W-1:0]    dib_q, dib_d;
  logic [EL_W-1:0]     el_q, el_d;
  logic                last_in_elem;
`ifdef MATRIX_UNLOADER_PREFETCH_EN
  logic [ROW_BITS-1:0] pf_q, pf_d;
`endif

  always_comb begin
    last_in_elem = (dib_q == DIB_W'(DIBITS - 1));
    last_dibit   = last_in_elem && (el_q == EL_W'(ELEMS - 1));
    dibit        = sreg_q[ROW_BITS-1 -: 2];
`ifdef MATRIX_UNLOADER_PREFETCH_EN
    first_dibit  = (dib_q == '0) && (el_q == '0);
`endif
  end

  always_comb begin
    sreg_d = sreg_q;
    dib_d  = dib_q;
    el_d   = el_q;
    if (load) begin
      sreg_d = row_in;
      dib_d  = '0;
      el_d   = '0;
    end else if (shift) begin
      sreg_d = {sreg_q[ROW_BITS-3:0], 2'b00};
      dib_d  = last_in_elem ? '0 : dib_q + 1'b1;
      if (last_in_elem) el_d = last_dibit ? '0 : el_q + 1'b1;
`ifdef MATRIX_UNLOADER_PREFETCH_EN
      // The row just finished; the prefetched row takes over on the same edge.
      if (last_dibit && swap) sreg_d = pf_q;
`endif
    end
  end

`ifdef MATRIX_UNLOADER_PREFETCH_EN
  always_comb begin
    pf_d = pf_q;
    if (pf_load) pf_d = row_in;
  end

  always_ff @(posedge clk) begin
    pf_q <= pf_d;
  end
`endif

  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dib_q <= '0;
      el_q  <= '0;
    end else begin
      dib_q <= dib_d;
      el_q  <= el_d;
    end
  end

endmodule

// File: rtl/matrix_unloader.sv
// Reads a result matrix row by row from BRAM and streams it as dibits toward the
// Ethernet TX path. Define MATRIX_UNLOADER_PREFETCH_EN for gapless row-to-row streaming.
module matrix_unloader
  import matrix_pkg::*;
#(
  parameter int MAX_ELEMENT_SIZE = matrix_pkg::MAX_ELEMENT_SIZE,
  parameter int MAX_SIZE         = matrix_pkg::MAX_SIZE,
  parameter int READ_LATENCY     = 2
) (
  input  logic                                 eth_refclk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic [$clog2(MAX_SIZE)-1:0]          rd_addr,
  output logic                                 rd_en,
  input  logic [MAX_SIZE*MAX_ELEMENT_SIZE-1:0] rd_data,
  input  logic                                 axiord,
  output logic                                 axiov,
  output logic [1:0]                           axiod,
  output logic                                 busy,
  output logic                                 done
);

  localparam int              AW       = $clog2(MAX_SIZE);
  localparam logic [AW-1:0]   LAST_ROW = AW'(MAX_SIZE - 1);

  state_t                  state_q, state_d;
  logic [AW-1:0]           row_q, row_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic                    rd_en_q, rd_en_d;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic                    xfer, row_end, ser_load;
  logic [1:0]              ser_dibit;
  logic                    last_dibit;
`ifdef MATRIX_UNLOADER_PREFETCH_EN
  logic                    pf_load, swap, first_dibit;
`endif

  assign xfer    = axiov && axiord;
  assign row_end = (state_q == SEND) && xfer && last_dibit;

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: if (rd_vld_q[READ_LATENCY-1]) state_d = SEND;
      SEND: begin
        if (row_end) begin
`ifdef MATRIX_UNLOADER_PREFETCH_EN
          if (row_q == LAST_ROW) state_d = DONE;
`else
          state_d = (row_q == LAST_ROW) ? DONE : FETCH;
`endif
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axiov = (state_q == SEND);
    axiod = axiov ? ser_dibit : 2'b00;
    busy  = (state_q == FETCH) || (state_q == SEND);
    done  = (state_q == DONE);
  end

  // rd_vld tracks each issued read through the BRAM pipeline; its MSB marks rd_data valid.
  always_comb begin
    row_d     = row_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_vld_d  = (rd_vld_q << 1) | READ_LATENCY'(rd_en_q);
    ser_load  = (state_q == FETCH) && rd_vld_q[READ_LATENCY-1];
`ifdef MATRIX_UNLOADER_PREFETCH_EN
    pf_load   = (state_q == SEND) && rd_vld_q[READ_LATENCY-1];
    swap      = 1'b0;
    if ((state_q == SEND) && xfer && first_dibit && (row_q != LAST_ROW)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = row_q + 1'b1;
    end
`endif
    if ((state_q == IDLE) && start) begin
      row_d     = '0;
      rd_en_d   = 1'b1;
      rd_addr_d = '0;
    end
    if (row_end) begin
      if (row_q != LAST_ROW) begin
        row_d = row_q + 1'b1;
`ifdef MATRIX_UNLOADER_PREFETCH_EN
        swap  = 1'b1;
`else
        rd_en_d   = 1'b1;
        rd_addr_d = row_q + 1'b1;
`endif
      end else begin
        row_d = '0;
      end
    end
  end

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_vld_q  <= '0;
    end else begin
      row_q     <= row_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;

  row_serializer #(
    .ROW_BITS (MAX_SIZE * MAX_ELEMENT_SIZE),
    .ELEMS    (MAX_SIZE),
    .DIBITS   (MAX_ELEMENT_SIZE / 2)
  ) u_ser (
    .clk         (eth_refclk),
    .rst_n       (rst_n),
    .load        (ser_load),
    .shift       (xfer),
`ifdef MATRIX_UNLOADER_PREFETCH_EN
    .pf_load     (pf_load),
    .swap        (swap),
    .first_dibit (first_dibit),
`endif
    .row_in      (rd_data),
    .dibit       (ser_dibit),
    .last_dibit  (last_dibit)
  );

endmodule

// File: tb/tb_matrix_unloader.sv
// Directed bench for matrix_unloader with a two-cycle-latency BRAM model.
// Expectations adapt to MATRIX_UNLOADER_PREFETCH_EN when it is defined.
module tb_matrix_unloader;

  localparam int N     = 32;
  localparam int TOTAL = 4096;
`ifdef MATRIX_UNLOADER_PREFETCH_EN
  localparam int EXP_GAPS = 0;
  localparam int EXP_DUR  = 4096;
`else
  localparam int EXP_GAPS = 31;
  localparam int EXP_DUR  = 4096 + 31 * 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         axiord = 1'b0;
  logic [4:0]   rd_addr;
  logic         rd_en;
  logic [255:0] rd_data;
  logic         axiov;
  logic [1:0]   axiod;
  logic         busy;
  logic         done;

  logic [255:0] mem [N];
  logic [255:0] pipe1, pipe2;
  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  matrix_unloader dut (
    .eth_refclk (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .axiord     (axiord),
    .axiov      (axiov),
    .axiod      (axiod),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk) begin
    if (rd_en) pipe1 <= mem[rd_addr];
    pipe2 <= pipe1;
  end
  assign rd_data = pipe2;

  function automatic logic [255:0] row_img(input int r);
    logic [255:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[255-8*c -: 8] = 8'((r * 32 + c) & 255);
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int stall_at, input int stall_len, input int dup_start_at,
                     input int abort_at);
    int k = 0, stalled = 0, gap = 0, ngaps = 0, cyc = 0;
    int first_cyc = -1, done_cyc = -1, ndone = 0;
    logic [255:0] rowv = '0;
    logic [15:0]  first8 = '0;
    bit dup_sent = 1'b0;
    start  = 1'b1;
    axiord = 1'b1;
    while (cyc < 6000) begin
      tick();
      cyc++;
      start  = 1'b0;
      axiord = 1'b1;
      if (k == dup_start_at && !dup_sent) begin
        start    = 1'b1;
        dup_sent = 1'b1;
      end
      if (k == stall_at && axiov && stalled < stall_len) begin
        axiord = 1'b0;
        stalled++;
        check("stall_hold_d", axiod, 2'b10);
        check("stall_hold_v", axiov, 1'b1);
      end
      if (axiov) begin
        if (gap > 0) begin
          ngaps++;
          check("gap_len", gap, 3);
          gap = 0;
        end
      end else if (k > 0 && k < TOTAL) begin
        gap++;
      end
      if (axiov && axiord) begin
        if (first_cyc < 0) first_cyc = cyc;
        rowv = {rowv[253:0], axiod};
        if (k < 8) first8 = {first8[13:0], axiod};
        k++;
        if (k == 8) check("first8", first8, 16'h0001);
        if (k % 128 == 0) check($sformatf("row%0d", k / 128 - 1), rowv, row_img(k / 128 - 1));
        if (k == TOTAL) check("last_elem", rowv[7:0], 8'hFF);
        if (abort_at >= 0 && k == abort_at) return;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        check("done_after_last", k, TOTAL);
        check("busy_with_done", busy, 1'b0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    check("transfers", k, TOTAL);
    check("done_pulses", ndone, 1);
    check("busy_after", busy, 1'b0);
    check("gap_count", ngaps, EXP_GAPS);
    // Cycles from the first transfer's cycle to the done cycle.
    if (stall_len == 0) check("duration", done_cyc - first_cyc, EXP_DUR);
  endtask

  initial begin
    for (int r = 0; r < N; r++) mem[r] = row_img(r);

    tick();
    tick();
    check("rst_axiov", axiov, 1'b0);
    check("rst_axiod", axiod, 2'b00);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();

    // Start latency: E0 accepts start, first dibit is valid after E3.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("e0_rd_en", rd_en, 1'b1);
    check("e0_rd_addr", rd_addr, 5'd0);
    check("e0_busy", busy, 1'b1);
    check("e0_axiov", axiov, 1'b0);
    tick();
    check("e1_axiov", axiov, 1'b0);
    check("e1_rd_en", rd_en, 1'b0);
    tick();
    check("e2_axiov", axiov, 1'b0);
    tick();
    check("e3_axiov", axiov, 1'b1);
    check("e3_axiod", axiod, 2'b00);
    rst_n = 1'b0;
    #1;
    check("async_rst_axiov", axiov, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    run(-1, 0, -1, -1);
    tick();
    run(426, 5, 100, -1);
    tick();

    run(-1, 0, -1, 7 * 128 + 50);
    rst_n = 1'b0;
    #1;
    check("row7_rst_axiov", axiov, 1'b0);
    check("row7_rst_rd_en", rd_en, 1'b0);
    check("row7_rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    run(-1, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
